// File: rtl/sum_dispatch_if.sv
// Request, response and dual-adder operand/return signals for sum_dispatch.
// Pure wiring: no latency of its own.
// Backpressure rides on in_ready (request side) and out_ready (result side).
// Optional out_carry member exists only when SUM_DISPATCH_CARRY_EN is defined.
interface sum_dispatch_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic       in_sel;

  logic [7:0] sum_a_a1;
  logic [7:0] sum_a_a2;
  logic [7:0] sum_a_ret;
  logic [7:0] sum_b_b1;
  logic [7:0] sum_b_b2;
  logic [7:0] sum_b_ret;

  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_sel;
`ifdef SUM_DISPATCH_CARRY_EN
  logic       out_carry;
`endif

  // master: the dispatcher itself; slave: producer, adder and consumer around it
  modport master (
    input  in_valid, in_a, in_b, in_sel, sum_a_ret, sum_b_ret, out_ready,
    output in_ready, sum_a_a1, sum_a_a2, sum_b_b1, sum_b_b2,
           out_valid, out_data, out_sel
`ifdef SUM_DISPATCH_CARRY_EN
           , out_carry
`endif
  );

  modport slave (
    output in_valid, in_a, in_b, in_sel, sum_a_ret, sum_b_ret, out_ready,
    input  in_ready, sum_a_a1, sum_a_a2, sum_b_b1, sum_b_b2,
           out_valid, out_data, out_sel
`ifdef SUM_DISPATCH_CARRY_EN
           , out_carry
`endif
  );
endinterface

// File: rtl/sum_dispatch.sv
// Feeds queued operand pairs to a dual 8-bit adder and registers the returned sum.
// Latency: push at edge N -> out_valid after edge N+1; one result per cycle sustained.
// Backpressure: in_ready = !full; issue stalls while out_valid && !out_ready.
// Optional out_carry (add overflow flag) is built when SUM_DISPATCH_CARRY_EN is defined.
module sum_dispatch #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  sum_dispatch_if.master   bus,
  output logic [CNT_W-1:0] ops_done,
  output logic             busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       sel;
  } req_t;

  typedef enum logic [1:0] {IDLE, RUN, STALL} state_t;

  req_t         mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_nxt;
  req_t          head;
  logic          fifo_nonempty, full, issue, push;
  logic [7:0]    ret_sel;
  logic          out_valid_q, out_valid_nxt, out_sel_q;
  logic [7:0]    out_data_q;
  state_t        state, state_nxt;

  // Head-of-queue decode and the issue/push qualifiers
  always_comb begin
    head          = mem[rd_ptr];
    fifo_nonempty = (count != '0);
    full          = (count == FULL_CNT);
    issue         = fifo_nonempty && (!out_valid_q || bus.out_ready) && !flush;
    push          = bus.in_valid && !full && !flush;
    ret_sel       = head.sel ? bus.sum_b_ret : bus.sum_a_ret;
  end

  // Only the selected adder port sees operands, and only on an issue cycle
  assign bus.sum_a_a1 = (issue && !head.sel) ? head.a : 8'd0;
  assign bus.sum_a_a2 = (issue && !head.sel) ? head.b : 8'd0;
  assign bus.sum_b_b1 = (issue &&  head.sel) ? head.a : 8'd0;
  assign bus.sum_b_b2 = (issue &&  head.sel) ? head.b : 8'd0;

  assign bus.in_ready  = !full;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;
  assign busy          = (state != IDLE);

  // Next FIFO occupancy and output-valid; flush empties the queue and drops any push
  always_comb begin
    count_nxt = count;
    unique case ({push, issue})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
    if (flush) count_nxt = '0;

    out_valid_nxt = out_valid_q;
    if (issue)                          out_valid_nxt = 1'b1;
    else if (out_valid_q && bus.out_ready) out_valid_nxt = 1'b0;
  end

  // Next state derived from what the queue and output register will hold after this edge
  always_comb begin
    state_nxt = RUN;
    if (count_nxt == '0 && !out_valid_nxt)
      state_nxt = IDLE;
    else if (out_valid_nxt && !bus.out_ready && count_nxt != '0)
      state_nxt = STALL;
  end

  // Request storage; pointers alone define validity so entries need no reset
  always_ff @(posedge clock) begin
    if (!reset && push) mem[wr_ptr] <= '{a: bus.in_a, b: bus.in_b, sel: bus.in_sel};
  end

  // Queue pointers, output register, completion counter and state
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'd0;
      out_sel_q   <= 1'b0;
      ops_done    <= '0;
      state       <= IDLE;
    end else begin
      count       <= count_nxt;
      out_valid_q <= out_valid_nxt;
      state       <= state_nxt;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push)  wr_ptr <= wr_ptr + 1'b1;
        if (issue) rd_ptr <= rd_ptr + 1'b1;
      end
      if (issue) begin
        out_data_q <= ret_sel;
        out_sel_q  <= head.sel;
        ops_done   <= ops_done + 1'b1;
      end
    end
  end

`ifdef SUM_DISPATCH_CARRY_EN
  logic out_carry_q;
  assign bus.out_carry = out_carry_q;

  // A wrapped 8-bit sum is smaller than its first operand exactly when the add overflowed
  always_ff @(posedge clock) begin
    if (reset)      out_carry_q <= 1'b0;
    else if (issue) out_carry_q <= (ret_sel < head.a);
  end
`endif

endmodule

// File: tb/tb_sum_dispatch.sv
// Randomised and directed bench for sum_dispatch against a queue-based reference model.
// Checks combinational operand drive before each edge and registered outputs after it.
// Adder is modelled inline; out_carry is checked when SUM_DISPATCH_CARRY_EN is defined.
module tb_sum_dispatch;
  localparam int DEPTH = 4;
  localparam int CNT_W = 4;

  logic             clock = 1'b0;
  logic             reset;
  logic             flush;
  logic [CNT_W-1:0] ops_done;
  logic             busy;

  sum_dispatch_if bus();

  always #5 clock = ~clock;

  // The external dual adder: combinational, mod-256
  assign bus.sum_a_ret = bus.sum_a_a1 + bus.sum_a_a2;
  assign bus.sum_b_ret = bus.sum_b_b1 + bus.sum_b_b2;

  sum_dispatch #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock    (clock),
    .reset    (reset),
    .flush    (flush),
    .bus      (bus),
    .ops_done (ops_done),
    .busy     (busy)
  );

  typedef struct {
    int a;
    int b;
    bit sel;
  } mreq_t;

  mreq_t q[$];
  bit    m_valid;
  int    m_data;
  bit    m_sel;
  bit    m_carry;
  int    m_ops;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check operand drive, apply edge to model, check outputs
  task automatic cyc(input bit iv, input int a, input int b, input bit sel,
                     input bit fl, input bit ordy, input bit rs);
    bit    iss;
    bit    was_full;
    int    ea1, ea2, eb1, eb2, s;
    mreq_t h;
    @(negedge clock);
    bus.in_valid  = iv;
    bus.in_a      = a[7:0];
    bus.in_b      = b[7:0];
    bus.in_sel    = sel;
    bus.out_ready = ordy;
    flush         = fl;
    reset         = rs;
    #1;
    iss      = (q.size() > 0) && (!m_valid || ordy) && !fl;
    was_full = (q.size() == DEPTH);
    ea1 = 0; ea2 = 0; eb1 = 0; eb2 = 0;
    if (iss) begin
      if (q[0].sel) begin eb1 = q[0].a; eb2 = q[0].b; end
      else          begin ea1 = q[0].a; ea2 = q[0].b; end
    end
    if (!rs) begin
      check("in_ready", bus.in_ready, !was_full);
      check("sum_a_a1", bus.sum_a_a1, ea1);
      check("sum_a_a2", bus.sum_a_a2, ea2);
      check("sum_b_b1", bus.sum_b_b1, eb1);
      check("sum_b_b2", bus.sum_b_b2, eb2);
    end
    @(posedge clock);
    if (rs) begin
      q.delete();
      m_valid = 0; m_data = 0; m_sel = 0; m_carry = 0; m_ops = 0;
    end else begin
      if (iss) begin
        h       = q.pop_front();
        s       = h.a + h.b;
        m_data  = s % 256;
        m_sel   = h.sel;
        m_carry = (s > 255);
        m_valid = 1;
        m_ops   = (m_ops + 1) % (1 << CNT_W);
      end else if (m_valid && ordy) begin
        m_valid = 0;
      end
      if (fl) q.delete();
      if (iv && !was_full && !fl) q.push_back('{a: a % 256, b: b % 256, sel: sel});
    end
    #1;
    check("out_valid", bus.out_valid, m_valid);
    check("out_data",  bus.out_data,  m_data);
    check("out_sel",   bus.out_sel,   m_sel);
    check("ops_done",  ops_done,      m_ops);
    check("busy",      busy,          m_valid || (q.size() != 0));
`ifdef SUM_DISPATCH_CARRY_EN
    check("out_carry", bus.out_carry, m_carry);
`endif
  endtask

  task automatic idle(input int n, input bit ordy);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, ordy, 0);
  endtask

  initial begin
    bus.in_valid = 0; bus.in_a = 0; bus.in_b = 0; bus.in_sel = 0;
    bus.out_ready = 0; flush = 0; reset = 1;

    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_ops_done", ops_done, 0);

    // Single request on port A
    cyc(1, 1, 2, 0, 0, 1, 0);
    idle(2, 1);
    check("single_data", bus.out_data, 3);
    check("single_ops", ops_done, 1);

    // Back-to-back B, B, A
    cyc(1, 3, 4, 1, 0, 1, 0);
    cyc(1, 5, 6, 1, 0, 1, 0);
    cyc(1, 1, 2, 0, 0, 1, 0);
    idle(4, 1);

    // Fill the queue under backpressure, then drain
    for (int i = 0; i < 6; i++) cyc(1, 10 + i, 3 * i, i % 2, 0, 0, 0);
    check("full_in_ready", bus.in_ready, 0);
    check("full_busy", busy, 1);
    idle(8, 1);

    // Mod-256 wrap and carry
    cyc(1, 200, 100, 0, 0, 1, 0);
    idle(2, 1);
    check("wrap_data", bus.out_data, 44);
    cyc(1, 10, 20, 0, 0, 1, 0);
    idle(2, 1);
    check("nowrap_data", bus.out_data, 30);

    // Flush with one held result and three queued
    for (int i = 0; i < 4; i++) cyc(1, 7 * i, 9, 1, 0, 0, 0);
    cyc(1, 99, 99, 0, 1, 0, 0);
    idle(3, 1);
    check("flush_empty_busy", busy, 0);

    // Reset with requests queued, then counter wrap over 17 operations
    for (int i = 0; i < 3; i++) cyc(1, i, i, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    check("midreset_valid", bus.out_valid, 0);
    for (int i = 0; i < 17; i++) cyc(1, $urandom_range(0, 255), $urandom_range(0, 255), i % 2, 0, 1, 0);
    idle(3, 1);
    check("cnt_wrap", ops_done, 1);

    // Random traffic
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 255), $urandom_range(0, 255),
          $urandom_range(0, 1) == 1, $urandom_range(0, 31) == 0,
          $urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0);
    idle(8, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
